// File: rtl/dram_line_if.sv
// CPU word bus and downstream line bus of the DRAM line adapter, bundled together.
// The adapter takes the slave view; the CPU/DRAM side (or a bench) takes the master view.
interface dram_line_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LINE_BITS  = 256,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                      cpu_cyc_i;
   logic                      cpu_stb_i;
   logic                      cpu_we_i;
   logic [ADDR_WIDTH-1:0]     cpu_addr_i;
   logic [DATA_WIDTH-1:0]     cpu_data_i;
   logic [DATA_WIDTH/8-1:0]   cpu_sel_i;
   logic [DATA_WIDTH-1:0]     cpu_data_o;
   logic                      cpu_ack_o;

   logic                      mem_cyc_o;
   logic                      mem_stb_o;
   logic                      mem_we_o;
   logic [ADDR_WIDTH-1:0]     mem_addr_o;
   logic [LINE_BITS-1:0]      mem_data_o;
   logic [LINE_BITS-1:0]      mem_data_i;
   logic                      mem_ack_i;

   modport slave (
      input  cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_addr_i, cpu_data_i, cpu_sel_i,
      output cpu_data_o, cpu_ack_o,
      output mem_cyc_o, mem_stb_o, mem_we_o, mem_addr_o, mem_data_o,
      input  mem_data_i, mem_ack_i
   );

   modport master (
      output cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_addr_i, cpu_data_i, cpu_sel_i,
      input  cpu_data_o, cpu_ack_o,
      input  mem_cyc_o, mem_stb_o, mem_we_o, mem_addr_o, mem_data_o,
      output mem_data_i, mem_ack_i
   );
endinterface

// File: rtl/dram_line_adapter.sv
// Single-line write-back, write-allocate buffer turning 32-bit byte-select CPU
// Wishbone accesses into whole-line Wishbone transactions, with explicit flush.
module dram_line_adapter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LINE_BITS  = 256,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        dram_ready_i,
   input  logic        flush_i,
   output logic        flush_done_o,
   dram_line_if.slave  bus
);
   localparam int unsigned OFF   = $clog2(LINE_BITS / 8);
   localparam int unsigned WOFF  = $clog2(DATA_WIDTH / 8);
   localparam int unsigned WIDX  = OFF - WOFF;
   localparam int unsigned TAG_W = ADDR_WIDTH - OFF;
   localparam int unsigned SEL_W = DATA_WIDTH / 8;
   localparam int unsigned WORDS = LINE_BITS / DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE, WRITEBACK, FILL, RESPOND, FLUSH_WB, FLUSH_DONE
   } state_t;

   state_t                 state;
   logic [LINE_BITS-1:0]   line;
   logic [TAG_W-1:0]       tag_q;
   logic                   valid;
   logic                   dirty;
   logic                   flush_pend;
   logic [TAG_W-1:0]       req_tag;
   logic [WIDX-1:0]        req_word;
   logic                   req_we;
   logic [DATA_WIDTH-1:0]  req_data;
   logic [SEL_W-1:0]       req_sel;

   logic                   cpu_req_c;
   logic                   hit_c;
   logic [TAG_W-1:0]       cpu_tag_c;
   logic [WIDX-1:0]        cpu_word_c;

   assign cpu_tag_c  = bus.cpu_addr_i[ADDR_WIDTH-1:OFF];
   assign cpu_word_c = bus.cpu_addr_i[OFF-1:WOFF];
   assign cpu_req_c  = bus.cpu_cyc_i & bus.cpu_stb_i & dram_ready_i;
   assign hit_c      = valid && (tag_q == cpu_tag_c);

   // Byte-within-word address bits carry no information for whole-word accesses.
   generate
      if (WOFF > 0) begin : g_unused
         logic unused_addr_bits;
         assign unused_addr_bits = ^bus.cpu_addr_i[WOFF-1:0];
      end
   endgenerate

   function automatic logic [DATA_WIDTH-1:0] get_word(input logic [LINE_BITS-1:0] l,
                                                      input logic [WIDX-1:0] idx);
      logic [DATA_WIDTH-1:0] w;
      w = '0;
      for (int unsigned i = 0; i < WORDS; i++)
         if (idx == WIDX'(i)) w = l[i*DATA_WIDTH +: DATA_WIDTH];
      return w;
   endfunction

   function automatic logic [LINE_BITS-1:0] put_word(input logic [LINE_BITS-1:0] l,
                                                     input logic [WIDX-1:0] idx,
                                                     input logic [DATA_WIDTH-1:0] d,
                                                     input logic [SEL_W-1:0] sel);
      logic [LINE_BITS-1:0] r;
      r = l;
      for (int unsigned i = 0; i < WORDS; i++)
         for (int unsigned b = 0; b < SEL_W; b++)
            if (idx == WIDX'(i) && sel[b]) r[i*DATA_WIDTH + b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   // Line-side states raise cyc/stb on entry and drop them on the ack edge,
   // so every transaction is separated by at least one idle bus cycle.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         line           <= '0;
         tag_q          <= '0;
         valid          <= 1'b0;
         dirty          <= 1'b0;
         flush_pend     <= 1'b0;
         req_tag        <= '0;
         req_word       <= '0;
         req_we         <= 1'b0;
         req_data       <= '0;
         req_sel        <= '0;
         flush_done_o   <= 1'b0;
         bus.cpu_data_o <= '0;
         bus.cpu_ack_o  <= 1'b0;
         bus.mem_cyc_o  <= 1'b0;
         bus.mem_stb_o  <= 1'b0;
         bus.mem_we_o   <= 1'b0;
         bus.mem_addr_o <= '0;
         bus.mem_data_o <= '0;
      end else begin
         bus.cpu_ack_o <= 1'b0;
         flush_done_o  <= 1'b0;
         if (flush_i && state != IDLE) flush_pend <= 1'b1;

         case (state)
            IDLE: begin
               if (cpu_req_c) begin
                  if (flush_i) flush_pend <= 1'b1;
                  req_tag  <= cpu_tag_c;
                  req_word <= cpu_word_c;
                  req_we   <= bus.cpu_we_i;
                  req_data <= bus.cpu_data_i;
                  req_sel  <= bus.cpu_sel_i;
                  if (hit_c) begin
                     if (bus.cpu_we_i) begin
                        line  <= put_word(line, cpu_word_c, bus.cpu_data_i, bus.cpu_sel_i);
                        dirty <= 1'b1;
                     end else begin
                        bus.cpu_data_o <= get_word(line, cpu_word_c);
                     end
                     bus.cpu_ack_o <= 1'b1;
                     state         <= RESPOND;
                  end else if (valid && dirty) begin
                     state <= WRITEBACK;
                  end else begin
                     state <= FILL;
                  end
               end else if ((flush_pend || flush_i) && dram_ready_i) begin
                  if (dirty) begin
                     state <= FLUSH_WB;
                  end else begin
                     flush_done_o <= 1'b1;
                     state        <= FLUSH_DONE;
                  end
               end
            end

            WRITEBACK, FLUSH_WB: begin
               if (!bus.mem_cyc_o) begin
                  bus.mem_cyc_o  <= 1'b1;
                  bus.mem_stb_o  <= 1'b1;
                  bus.mem_we_o   <= 1'b1;
                  bus.mem_addr_o <= {tag_q, {OFF{1'b0}}};
                  bus.mem_data_o <= line;
               end else if (bus.mem_ack_i) begin
                  bus.mem_cyc_o <= 1'b0;
                  bus.mem_stb_o <= 1'b0;
                  bus.mem_we_o  <= 1'b0;
                  dirty         <= 1'b0;
                  if (state == WRITEBACK) begin
                     state <= FILL;
                  end else begin
                     flush_done_o <= 1'b1;
                     state        <= FLUSH_DONE;
                  end
               end
            end

            FILL: begin
               if (!bus.mem_cyc_o) begin
                  bus.mem_cyc_o  <= 1'b1;
                  bus.mem_stb_o  <= 1'b1;
                  bus.mem_we_o   <= 1'b0;
                  bus.mem_addr_o <= {req_tag, {OFF{1'b0}}};
               end else if (bus.mem_ack_i) begin
                  bus.mem_cyc_o  <= 1'b0;
                  bus.mem_stb_o  <= 1'b0;
                  tag_q          <= req_tag;
                  valid          <= 1'b1;
                  bus.cpu_data_o <= get_word(bus.mem_data_i, req_word);
                  if (req_we) begin
                     line  <= put_word(bus.mem_data_i, req_word, req_data, req_sel);
                     dirty <= 1'b1;
                  end else begin
                     line <= bus.mem_data_i;
                  end
                  bus.cpu_ack_o <= 1'b1;
                  state         <= RESPOND;
               end
            end

            RESPOND: state <= IDLE;

            FLUSH_DONE: begin
               flush_pend <= 1'b0;
               state      <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dram_line_adapter.sv
// Randomized bench for dram_line_adapter: a DRAM responder plus a golden
// CPU-visible memory and a one-line residency model predicting line traffic.
module tb_dram_line_adapter;
   logic sys_clk = 1'b0;
   logic rst_n = 1'b0;
   logic dram_ready = 1'b0;
   logic flush = 1'b0;
   logic flush_done;

   dram_line_if bus();

   dram_line_adapter dut (
      .sys_clk      (sys_clk),
      .rst_n        (rst_n),
      .dram_ready_i (dram_ready),
      .flush_i      (flush),
      .flush_done_o (flush_done),
      .bus          (bus)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct { bit we; int unsigned addr; } txn_t;

   int errors = 0;
   int checks = 0;
   txn_t exp_q[$];
   txn_t obs_q[$];
   logic [255:0] dram   [int unsigned];
   logic [255:0] glines [int unsigned];
   bit m_valid = 0;
   bit m_dirty = 0;
   int unsigned m_line = 0;
   int mem_delay = 0;
   bit stray = 0;
   int flush_cnt = 0;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial forever begin
      @(negedge sys_clk);
      if (flush_done === 1'b1) flush_cnt++;
   end

   // DRAM responder: acks each line request after mem_delay cycles.
   initial begin : responder
      int wait_cnt;
      wait_cnt = 0;
      bus.mem_ack_i = 1'b0;
      bus.mem_data_i = '0;
      forever begin
         @(negedge sys_clk);
         if (bus.mem_ack_i) begin
            bus.mem_ack_i = 1'b0;
         end else if (stray) begin
            bus.mem_ack_i = 1'b1;
            stray = 0;
         end else if (bus.mem_cyc_o && bus.mem_stb_o) begin
            if (wait_cnt >= mem_delay) begin
               wait_cnt = 0;
               checks++;
               if (bus.mem_addr_o[4:0] !== 5'd0) begin
                  errors++;
                  $display("FAIL mem_addr_align: addr=%h required low 5 bits 0", bus.mem_addr_o);
               end
               obs_q.push_back('{we: bus.mem_we_o, addr: bus.mem_addr_o});
               if (bus.mem_we_o) dram[bus.mem_addr_o] = bus.mem_data_o;
               else bus.mem_data_i = dram.exists(bus.mem_addr_o) ? dram[bus.mem_addr_o] : '0;
               bus.mem_ack_i = 1'b1;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   function automatic void touch(input int unsigned line);
      logic [255:0] v;
      if (!dram.exists(line)) begin
         for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
         dram[line] = v;
         glines[line] = v;
      end
   endfunction

   // Reference: CPU sees a flat memory; one resident line decides the traffic.
   task automatic model_access(input int unsigned addr, input bit we, input logic [31:0] data,
                               input logic [3:0] sel, output logic [31:0] rdata, output bit hit);
      int unsigned line;
      int w;
      logic [255:0] l;
      line = addr & 32'hFFFF_FFE0;
      w = int'((addr >> 2) & 7);
      touch(line);
      hit = m_valid && (m_line == line);
      if (!hit) begin
         if (m_valid && m_dirty) exp_q.push_back('{we: 1'b1, addr: m_line});
         exp_q.push_back('{we: 1'b0, addr: line});
         m_valid = 1; m_line = line; m_dirty = 0;
      end
      l = glines[line];
      rdata = l[w*32 +: 32];
      if (we) begin
         for (int b = 0; b < 4; b++) if (sel[b]) l[w*32 + b*8 +: 8] = data[b*8 +: 8];
         glines[line] = l;
         m_dirty = 1;
         rdata = '0;
      end
   endtask

   task automatic model_flush();
      if (m_valid && m_dirty) exp_q.push_back('{we: 1'b1, addr: m_line});
      m_dirty = 0;
   endtask

   function automatic bit traffic_ok();
      if (obs_q.size() != exp_q.size()) return 0;
      foreach (exp_q[i])
         if (obs_q[i].we != exp_q[i].we || obs_q[i].addr != exp_q[i].addr) return 0;
      return 1;
   endfunction

   function automatic void traffic_clear();
      obs_q.delete();
      exp_q.delete();
   endfunction

   task automatic cpu_access(input logic [31:0] addr, input bit we, input logic [31:0] data,
                             input logic [3:0] sel, output logic [31:0] rdata,
                             output int lat, output int acks);
      @(negedge sys_clk);
      bus.cpu_cyc_i = 1; bus.cpu_stb_i = 1; bus.cpu_we_i = we;
      bus.cpu_addr_i = addr; bus.cpu_data_i = data; bus.cpu_sel_i = sel;
      rdata = '0; lat = -1; acks = 0;
      for (int c = 1; c <= 600 && acks == 0; c++) begin
         @(negedge sys_clk);
         if (bus.cpu_ack_o) begin
            acks = 1; lat = c; rdata = bus.cpu_data_o;
         end
      end
      bus.cpu_cyc_i = 0; bus.cpu_stb_i = 0; bus.cpu_we_i = 0;
      repeat (3) begin
         @(negedge sys_clk);
         if (bus.cpu_ack_o) acks++;
      end
   endtask

   task automatic test_reset();
      bus.cpu_cyc_i = 0; bus.cpu_stb_i = 0; bus.cpu_we_i = 0;
      bus.cpu_addr_i = '0; bus.cpu_data_i = '0; bus.cpu_sel_i = '0;
      rst_n = 0;
      repeat (3) @(negedge sys_clk);
      checks++;
      if ({bus.cpu_ack_o, bus.mem_cyc_o, bus.mem_stb_o, bus.mem_we_o, flush_done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ack/cyc/stb/we/done=%b required 00000",
                  {bus.cpu_ack_o, bus.mem_cyc_o, bus.mem_stb_o, bus.mem_we_o, flush_done});
      end
      checks++;
      if (bus.cpu_data_o !== 32'h0 || bus.mem_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: cpu_data=%h mem_addr=%h required 0", bus.cpu_data_o, bus.mem_addr_o);
      end
      rst_n = 1; dram_ready = 1;
      repeat (2) @(negedge sys_clk);
      checks++;
      if ({bus.cpu_ack_o, bus.mem_cyc_o, flush_done} !== 3'b0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL post_reset_idle: ack/cyc/done=%b txns=%0d required quiet",
                  {bus.cpu_ack_o, bus.mem_cyc_o, flush_done}, obs_q.size());
      end
   endtask

   task automatic test_fill_read();
      logic [255:0] l;
      logic [31:0] exp_d, rd;
      bit hit;
      int lat, acks;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'h1000_0000 + 32'(i);
      dram[32'h40] = l; glines[32'h40] = l;
      model_access(32'h44, 0, '0, '0, exp_d, hit);
      cpu_access(32'h44, 0, '0, 4'hF, rd, lat, acks);
      checks++;
      if (acks != 1) begin errors++; $display("FAIL fill_read_acks: got %0d required 1", acks); end
      checks++;
      if (rd !== 32'h1000_0001 || rd !== exp_d) begin
         errors++; $display("FAIL fill_read_data: got %h required %h", rd, 32'h1000_0001);
      end
      checks++;
      if (!traffic_ok()) begin
         errors++; $display("FAIL fill_read_traffic: %0d txns required one read fill at 0x40", obs_q.size());
      end
      traffic_clear();
   endtask

   task automatic test_hit_write_read();
      logic [31:0] exp_d, rd;
      bit hit;
      int lat, acks;
      model_access(32'h48, 1, 32'hAABB_CCDD, 4'b0101, exp_d, hit);
      cpu_access(32'h48, 1, 32'hAABB_CCDD, 4'b0101, rd, lat, acks);
      checks++;
      if (acks != 1 || lat != 1) begin
         errors++; $display("FAIL hit_write_timing: acks=%0d lat=%0d required 1/1", acks, lat);
      end
      model_access(32'h48, 0, '0, '0, exp_d, hit);
      cpu_access(32'h48, 0, '0, 4'hF, rd, lat, acks);
      checks++;
      if (acks != 1 || lat != 1) begin
         errors++; $display("FAIL hit_read_timing: acks=%0d lat=%0d required 1/1", acks, lat);
      end
      checks++;
      if (rd !== 32'h10BB_00DD || rd !== exp_d) begin
         errors++; $display("FAIL hit_merge_data: got %h required 10bb00dd", rd);
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++; $display("FAIL hit_traffic: %0d txns required 0", obs_q.size());
      end
      traffic_clear();
   endtask

   task automatic test_dirty_miss();
      logic [31:0] exp_d, rd;
      logic [255:0] l;
      bit hit;
      int lat, acks;
      mem_delay = 20;
      model_access(32'h1000, 0, '0, '0, exp_d, hit);
      cpu_access(32'h1000, 0, '0, 4'hF, rd, lat, acks);
      mem_delay = 0;
      checks++;
      if (acks != 1 || lat < 42) begin
         errors++; $display("FAIL dirty_miss_ack: acks=%0d lat=%0d required 1 ack after both txns", acks, lat);
      end
      checks++;
      if (!traffic_ok()) begin
         errors++; $display("FAIL dirty_miss_order: %0d txns required write-back 0x40 then fill 0x1000", obs_q.size());
      end
      l = dram[32'h40];
      checks++;
      if (l[95:64] !== 32'h10BB_00DD || l !== glines[32'h40]) begin
         errors++; $display("FAIL writeback_data: word2=%h required 10bb00dd", l[95:64]);
      end
      checks++;
      if (rd !== exp_d) begin errors++; $display("FAIL dirty_miss_data: got %h required %h", rd, exp_d); end
      traffic_clear();
   endtask

   task automatic test_flush();
      logic [31:0] exp_d, rd;
      bit hit;
      int lat, acks, start;
      @(negedge sys_clk); flush = 1;
      @(negedge sys_clk); flush = 0;
      checks++;
      if (flush_done !== 1'b1) begin errors++; $display("FAIL clean_flush_pulse: got %b required 1", flush_done); end
      @(negedge sys_clk);
      checks++;
      if (flush_done !== 1'b0 || obs_q.size() != 0) begin
         errors++; $display("FAIL clean_flush_after: done=%b txns=%0d required 0/0", flush_done, obs_q.size());
      end
      mem_delay = 10;
      start = flush_cnt;
      model_access(32'h3008, 1, 32'hCAFE_F00D, 4'hF, exp_d, hit);
      model_flush();
      fork
         cpu_access(32'h3008, 1, 32'hCAFE_F00D, 4'hF, rd, lat, acks);
         begin
            repeat (3) @(negedge sys_clk); flush = 1;
            @(negedge sys_clk); flush = 0;
            repeat (3) @(negedge sys_clk); flush = 1;
            @(negedge sys_clk); flush = 0;
         end
      join
      for (int c = 0; c < 200 && flush_cnt == start; c++) @(negedge sys_clk);
      repeat (5) @(negedge sys_clk);
      mem_delay = 0;
      checks++;
      if (acks != 1) begin errors++; $display("FAIL flush_fill_ack: got %0d required 1", acks); end
      checks++;
      if (flush_cnt - start != 1) begin
         errors++; $display("FAIL flush_collapse: %0d done pulses required 1", flush_cnt - start);
      end
      checks++;
      if (!traffic_ok()) begin
         errors++; $display("FAIL flush_traffic: %0d txns required fill then write-back of 0x3000", obs_q.size());
      end
      checks++;
      if (dram[32'h3000] !== glines[32'h3000]) begin
         errors++; $display("FAIL flush_data: dram word2=%h required %h", dram[32'h3000][95:64], glines[32'h3000][95:64]);
      end
      traffic_clear();
   endtask

   task automatic test_ready_low();
      logic [31:0] exp_d, rd;
      bit hit;
      int acks;
      model_access(32'h44, 0, '0, '0, exp_d, hit);
      dram_ready = 0;
      @(negedge sys_clk);
      bus.cpu_cyc_i = 1; bus.cpu_stb_i = 1; bus.cpu_we_i = 0;
      bus.cpu_addr_i = 32'h44; bus.cpu_sel_i = 4'hF;
      stray = 1;
      acks = 0;
      repeat (20) begin
         @(negedge sys_clk);
         if (bus.cpu_ack_o) acks++;
      end
      checks++;
      if (acks != 0 || obs_q.size() != 0) begin
         errors++; $display("FAIL ready_low_block: acks=%0d txns=%0d required 0/0", acks, obs_q.size());
      end
      dram_ready = 1;
      rd = '0;
      for (int c = 0; c < 200 && acks == 0; c++) begin
         @(negedge sys_clk);
         if (bus.cpu_ack_o) begin acks = 1; rd = bus.cpu_data_o; end
      end
      bus.cpu_cyc_i = 0; bus.cpu_stb_i = 0;
      repeat (3) begin
         @(negedge sys_clk);
         if (bus.cpu_ack_o) acks++;
      end
      checks++;
      if (acks != 1 || rd !== exp_d) begin
         errors++; $display("FAIL ready_high_serve: acks=%0d data=%h required 1/%h", acks, rd, exp_d);
      end
      checks++;
      if (!traffic_ok()) begin
         errors++; $display("FAIL ready_high_traffic: %0d txns required one fill of 0x40", obs_q.size());
      end
      traffic_clear();
   endtask

   task automatic test_random();
      int unsigned lines [4];
      logic [31:0] exp_d, rd, data;
      logic [3:0] sel;
      int unsigned addr;
      bit hit, we;
      int lat, acks, start;
      lines[0] = 32'h0000; lines[1] = 32'h0040; lines[2] = 32'h1000; lines[3] = 32'h2000;
      for (int n = 0; n < 40; n++) begin
         addr = lines[$urandom_range(0, 3)] + 4 * $urandom_range(0, 7);
         we = 1'($urandom_range(0, 1));
         data = $urandom;
         sel = (n % 10 == 3) ? 4'h0 : 4'($urandom);
         mem_delay = $urandom_range(0, 6);
         model_access(addr, we, data, sel, exp_d, hit);
         cpu_access(addr, we, data, sel, rd, lat, acks);
         checks++;
         if (acks != 1) begin errors++; $display("FAIL rand_acks[%0d]: got %0d required 1", n, acks); end
         if (!we) begin
            checks++;
            if (rd !== exp_d) begin errors++; $display("FAIL rand_data[%0d]: addr=%h got %h required %h", n, addr, rd, exp_d); end
         end
         if (hit) begin
            checks++;
            if (lat != 1) begin errors++; $display("FAIL rand_hit_latency[%0d]: got %0d required 1", n, lat); end
         end
         checks++;
         if (!traffic_ok()) begin
            errors++; $display("FAIL rand_traffic[%0d]: %0d txns required %0d", n, obs_q.size(), exp_q.size());
         end
         traffic_clear();
      end
      start = flush_cnt;
      model_flush();
      @(negedge sys_clk); flush = 1;
      @(negedge sys_clk); flush = 0;
      for (int c = 0; c < 200 && flush_cnt == start; c++) @(negedge sys_clk);
      repeat (3) @(negedge sys_clk);
      mem_delay = 0;
      checks++;
      if (flush_cnt - start != 1 || !traffic_ok()) begin
         errors++; $display("FAIL rand_flush: pulses=%0d txns=%0d required 1/%0d", flush_cnt - start, obs_q.size(), exp_q.size());
      end
      foreach (lines[i]) begin
         checks++;
         if (dram[lines[i]] !== glines[lines[i]]) begin
            errors++; $display("FAIL rand_dram_image: line %h differs from CPU-visible contents", lines[i]);
         end
      end
      traffic_clear();
   endtask

   task automatic test_reset_mid_wb();
      logic [31:0] exp_d, rd;
      bit hit, seen;
      int lat, acks;
      int unsigned old_line, other;
      old_line = m_line;
      other = (m_line == 32'h1000) ? 32'h2000 : 32'h1000;
      model_access(old_line + 4, 1, 32'h5555_AAAA, 4'hF, exp_d, hit);
      cpu_access(old_line + 4, 1, 32'h5555_AAAA, 4'hF, rd, lat, acks);
      traffic_clear();
      mem_delay = 30;
      @(negedge sys_clk);
      bus.cpu_cyc_i = 1; bus.cpu_stb_i = 1; bus.cpu_we_i = 0;
      bus.cpu_addr_i = other; bus.cpu_sel_i = 4'hF;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge sys_clk);
         seen = bus.mem_cyc_o && bus.mem_we_o;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL mid_wb_start: write-back not seen, required within 20 cycles"); end
      #2 rst_n = 0;
      #1;
      checks++;
      if ({bus.mem_cyc_o, bus.mem_stb_o, bus.cpu_ack_o} !== 3'b000) begin
         errors++; $display("FAIL async_reset_drop: cyc/stb/ack=%b required 000", {bus.mem_cyc_o, bus.mem_stb_o, bus.cpu_ack_o});
      end
      bus.cpu_cyc_i = 0; bus.cpu_stb_i = 0;
      repeat (2) @(negedge sys_clk);
      rst_n = 1;
      mem_delay = 0;
      m_valid = 0; m_dirty = 0;
      foreach (glines[k]) glines[k] = dram[k];
      traffic_clear();
      model_access(old_line + 4, 0, '0, '0, exp_d, hit);
      cpu_access(old_line + 4, 0, '0, 4'hF, rd, lat, acks);
      checks++;
      if (!traffic_ok()) begin
         errors++; $display("FAIL post_reset_fill: %0d txns required one fill of %h", obs_q.size(), old_line);
      end
      checks++;
      if (acks != 1 || rd !== exp_d) begin
         errors++; $display("FAIL post_reset_data: acks=%0d data=%h required 1/%h", acks, rd, exp_d);
      end
      traffic_clear();
   endtask

   initial begin
      test_reset();
      test_fill_read();
      test_hit_write_read();
      test_dirty_miss();
      test_flush();
      test_ready_low();
      test_random();
      test_reset_mid_wb();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dram_line_adapter.md
Name: dram_line_adapter

Overview:
- Sits directly upstream of the DRAM wrapper.
- Converts 32-bit CPU Wishbone accesses with byte selects into whole-line 256-bit Wishbone transactions, which is what the wrapper accepts.
- Holds one write-back, write-allocate line buffer: repeated word accesses to the same line hit locally, and partial writes never reach DRAM as partial lines.
- Offers an explicit flush so software can force the dirty line out before DRAM is handed to another master.

Parameters:
- DATA_WIDTH, 32, CPU-side word width; power of 2, at least 8.
- LINE_BITS, 256, downstream line width; power-of-2 multiple of DATA_WIDTH.
- ADDR_WIDTH, 32, byte-address width on both sides.

Ports:
- sys_clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- dram_ready_i  in  1  DRAM initialized; no new CPU request or flush is started while low.
- flush_i  in  1  one-cycle request to write back the dirty line.
- flush_done_o  out  1  one-cycle pulse when the flush completes.
- cpu_cyc_i, cpu_stb_i, cpu_we_i  in  1 each  CPU Wishbone controls.
- cpu_addr_i  in  ADDR_WIDTH  CPU byte address.
- cpu_data_i  in  DATA_WIDTH  CPU write data.
- cpu_sel_i  in  DATA_WIDTH/8  byte enables.
- cpu_data_o  out  DATA_WIDTH  read data; valid while cpu_ack_o is high.
- cpu_ack_o  out  1  one-cycle ack pulse.
- mem_cyc_o, mem_stb_o, mem_we_o  out  1 each  line-side Wishbone controls.
- mem_addr_o  out  ADDR_WIDTH  line byte address; offset bits are always 0.
- mem_data_o  out  LINE_BITS  write-back data.
- mem_data_i  in  LINE_BITS  fill data.
- mem_ack_i  in  1  line-side ack; may arrive any number of cycles after the request.

Behaviour:
- Address fields:
  - OFF = log2(LINE_BITS/8) (5 at defaults).
  - tag = addr[ADDR_WIDTH-1:OFF].
  - word index = addr[OFF-1:log2(DATA_WIDTH/8)] (addr[4:2] at defaults).
  - Word i occupies line bits [DATA_WIDTH*i +: DATA_WIDTH].
- State: line[LINE_BITS], tag_q, valid, dirty, flush_pend.
- Reset values: all outputs 0; valid=0, dirty=0, flush_pend=0; state IDLE.
- States: IDLE, WRITEBACK, FILL, RESPOND, FLUSH_WB, FLUSH_DONE.
- IDLE
  - Accepts a CPU request when cpu_cyc_i & cpu_stb_i & dram_ready_i.
  - Hit (valid and tag match):
    - Read: capture the selected word into cpu_data_o.
    - Write: merge cpu_data_i into the selected word byte-wise per cpu_sel_i, and set dirty=1.
    - Go to RESPOND.
  - Miss with valid & dirty: go to WRITEBACK. Miss otherwise: go to FILL. The request fields are latched in both cases.
  - With no CPU request, flush_pend | flush_i, and dram_ready_i:
    - dirty set: go to FLUSH_WB.
    - dirty clear: go to FLUSH_DONE.
  - A CPU request has priority over a flush.
- WRITEBACK
  - Drives mem_cyc_o=mem_stb_o=mem_we_o=1, mem_addr_o={tag_q, OFF zeros}, mem_data_o=line.
  - Holds these until mem_ack_i. On the ack edge, clears the controls, sets dirty=0, goes to FILL.
- FILL
  - Drives cyc=stb=1, we=0, mem_addr_o={latched tag, zeros}.
  - On mem_ack_i: line<=mem_data_i, tag_q<=latched tag, valid=1.
  - Then applies the latched operation as on a hit (write sets dirty=1) and goes to RESPOND.
- RESPOND
  - cpu_ack_o=1 for exactly one cycle, then IDLE.
  - No CPU request is sampled in this cycle, so a master still holding stb does not issue a duplicate.
- FLUSH_WB
  - Same bus behaviour as WRITEBACK.
  - On ack: dirty=0, valid stays 1, go to FLUSH_DONE.
- FLUSH_DONE
  - flush_done_o=1 for one cycle; clear flush_pend; go to IDLE.
- Timing:
  - mem_cyc_o/mem_stb_o are registered. They fall in the cycle after mem_ack_i is seen, and never stay high for a second transaction.
  - Hit latency: ack in the cycle after acceptance (1 cycle). Hit throughput: one access per 2 cycles.
  - Clean miss: 1 line transaction, then 1 RESPOND cycle.
  - Dirty miss: write-back strictly before fill; the fill address is never issued before the write-back ack.
- Boundary conditions:
  - flush_i in any non-IDLE state sets flush_pend; it is served on return to IDLE. Multiple flush_i pulses while pending collapse into one flush_done_o.
  - mem_ack_i outside WRITEBACK, FILL or FLUSH_WB is ignored.
  - cpu_sel_i=0 write: acts as a write of no bytes, but still sets dirty and still acks.
  - Read miss to the same tag as a clean invalidated line: FILL only.
  - dram_ready_i falling mid-transaction does not abort it; it only blocks new starts.
  - rst_n low at any time, including mid line-transaction: immediate return to reset values and drop of mem_cyc_o/mem_stb_o. Buffered dirty data is lost; the downstream wrapper is reset on the same rst_n.

Test Plan:
- Reset, dram_ready_i=1, read 0x0000_0044 -> FILL at mem_addr_o 0x0000_0040; return line with word i = 0x1000_0000+i -> cpu_data_o=0x1000_0001 with a single ack; no mem_we_o.
- Write 0xAABBCCDD, sel=4'b0101, to 0x0000_0048 after the above, then read it back -> both hit, no mem transaction; read returns 0x10BB00DD, i.e. 0x1000_0002 with bytes 0 and 2 replaced.
- Read 0x0000_1000 while dirty -> write-back to 0x0000_0040 carrying the merged line, completing before the FILL to 0x0000_1000; delay mem_ack_i 20 cycles each -> exactly one ack to the CPU after both complete.
- flush_i while clean -> flush_done_o pulse 1 cycle later, no mem traffic. flush_i pulsed twice during a FILL -> one dirty write-back if applicable, then one flush_done_o.
- dram_ready_i=0 with cpu_stb_i held -> no ack, no mem traffic; raise dram_ready_i -> request served normally.
- Assert rst_n=0 mid-WRITEBACK -> mem_cyc_o, mem_stb_o, cpu_ack_o are 0 without waiting for a clock edge; next read of the same address performs a FILL (valid cleared).
